// File: rtl/linebuffer_xy_l_pkg.sv
// ============================================================================
// Module   : linebuffer_xy_l_pkg
// Brief    : Shared image geometry, pixel width and FSM encoding for the line buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package linebuffer_xy_l_pkg;

    localparam int c_PIXEL_WIDTH = 11;
    localparam int c_IMG_WIDTH   = 640;
    localparam int c_IMG_HEIGHT  = 480;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    // Counter width that never collapses to zero for a single-entry dimension
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/linebuffer_xy_l_if.sv
// ============================================================================
// Module   : linebuffer_xy_l_if
// Brief    : Pixel stream in, two-row window feed out.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface linebuffer_xy_l_if
    import linebuffer_xy_l_pkg::*;
#(
    parameter int PIXEL_WIDTH = c_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = c_IMG_WIDTH,
    parameter int IMG_HEIGHT  = c_IMG_HEIGHT
);
    localparam int c_COL_W = cnt_width(IMG_WIDTH);
    localparam int c_ROW_W = cnt_width(IMG_HEIGHT);

    logic [PIXEL_WIDTH-1:0] pix_in;
    logic                   pix_valid;
    logic                   sof;
    logic [PIXEL_WIDTH-1:0] linebuffer0;
    logic [PIXEL_WIDTH-1:0] linebuffer1;
    logic                   clken;
    logic [c_COL_W-1:0]     col_cnt;
    logic [c_ROW_W-1:0]     row_cnt;
    logic                   frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  linebuffer0, linebuffer1, clken, col_cnt, row_cnt, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output linebuffer0, linebuffer1, clken, col_cnt, row_cnt, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/linebuffer_xy_l_line_ram.sv
// ============================================================================
// Module   : linebuffer_xy_l_line_ram
// Brief    : One-row single-port read-before-write RAM, synchronous read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module linebuffer_xy_l_line_ram #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  wire logic              clock,
    input  wire logic              i_en,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_en) begin
            o_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/linebuffer_xy_l.sv
// ============================================================================
// Module   : linebuffer_xy_l
// Brief    : Raster line buffer pairing each pixel with the one above it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module linebuffer_xy_l
    import linebuffer_xy_l_pkg::*;
#(
    parameter int PIXEL_WIDTH = c_PIXEL_WIDTH,
    parameter int IMG_WIDTH   = c_IMG_WIDTH,
    parameter int IMG_HEIGHT  = c_IMG_HEIGHT
) (
    input  wire logic         clock,
    input  wire logic         rst,
    linebuffer_xy_l_if.slave  bus
);

    localparam int c_COL_W = cnt_width(IMG_WIDTH);
    localparam int c_ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic [0:0]             r_state;
    logic [c_COL_W-1:0]     r_col;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_COL_W-1:0]     r_col_out;
    logic [c_ROW_W-1:0]     r_row_out;
    logic [PIXEL_WIDTH-1:0] r_lb0;
    logic                   r_clken;
    logic                   r_frame_done;

    logic                   w_accept;
    logic [c_COL_W-1:0]     w_pix_col;
    logic [c_ROW_W-1:0]     w_pix_row;
    logic                   w_last;
    logic [PIXEL_WIDTH-1:0] w_ram_q;

    // A sof pixel is always (0,0), even when it interrupts a running frame
    assign w_accept  = bus.pix_valid && (bus.sof || (r_state == c_ST_ACTIVE));
    assign w_pix_col = bus.sof ? '0 : r_col;
    assign w_pix_row = bus.sof ? '0 : r_row;
    assign w_last    = (w_pix_col == c_COL_LAST) && (w_pix_row == c_ROW_LAST);

    linebuffer_xy_l_line_ram #(
        .DATA_W (PIXEL_WIDTH),
        .DEPTH  (IMG_WIDTH),
        .ADDR_W (c_COL_W)
    ) u_line_ram (
        .clock   (clock),
        .i_en    (w_accept),
        .i_addr  (w_pix_col),
        .i_wdata (bus.pix_in),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_col_out    <= '0;
            r_row_out    <= '0;
            r_lb0        <= '0;
            r_clken      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_clken      <= w_accept;
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                r_lb0     <= bus.pix_in;
                r_col_out <= w_pix_col;
                r_row_out <= w_pix_row;
                if (w_last) begin
                    r_state <= c_ST_IDLE;
                    r_col   <= '0;
                    r_row   <= '0;
                end else begin
                    r_state <= c_ST_ACTIVE;
                    if (w_pix_col == c_COL_LAST) begin
                        r_col <= '0;
                        r_row <= w_pix_row + 1'b1;
                    end else begin
                        r_col <= w_pix_col + 1'b1;
                    end
                end
            end
        end
    end

    // Row 0 has no valid row above it; masking also hides RAM left by earlier frames
    assign bus.linebuffer0 = r_lb0;
    assign bus.linebuffer1 = (r_row_out == '0) ? '0 : w_ram_q;
    assign bus.clken       = r_clken;
    assign bus.col_cnt     = r_col_out;
    assign bus.row_cnt     = r_row_out;
    assign bus.frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_linebuffer_xy_l.sv
// ============================================================================
// Module   : tb_linebuffer_xy_l
// Brief    : Self-checking bench for linebuffer_xy_l on a 4x3 image.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_linebuffer_xy_l;

    localparam int PW = 11;
    localparam int W  = 4;
    localparam int H  = 3;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    linebuffer_xy_l_if #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    linebuffer_xy_l #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [PW-1:0] lb0;
        logic [PW-1:0] lb1;
        int            col;
        int            row;
        logic          fd;
    } exp_t;

    typedef struct {
        logic      sof;
        logic [PW-1:0] pix;
        exp_t      exp;
    } vec_t;

    exp_t q[$];
    exp_t last;
    vec_t tbl[12];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fd_seen = 0;

    logic [PW-1:0] m_ram [W];
    bit            m_active;
    int            m_col;
    int            m_row;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pops one expectation per clken, otherwise outputs must hold
    always @(negedge clock) begin
        exp_t e;
        if (!rst) begin
            last = '{default: 0};
        end else if (bus.clken) begin
            if (q.size() == 0) begin
                chk("unexpected clken", 1, 0);
            end else begin
                e = q.pop_front();
                chk("lb0", bus.linebuffer0, e.lb0);
                chk("lb1", bus.linebuffer1, e.lb1);
                chk("col_cnt", bus.col_cnt, e.col);
                chk("row_cnt", bus.row_cnt, e.row);
                chk("frame_done", bus.frame_done, e.fd);
                if (bus.frame_done) fd_seen++;
                last = e;
            end
        end else begin
            chk("hold lb0", bus.linebuffer0, last.lb0);
            chk("hold lb1", bus.linebuffer1, last.lb1);
            chk("hold col_cnt", bus.col_cnt, last.col);
            chk("hold row_cnt", bus.row_cnt, last.row);
            chk("idle frame_done", bus.frame_done, 0);
        end
    end

    // Drive one cycle; the reference model decides acceptance and pushes the expectation
    task automatic step(input bit v, input bit s, input logic [PW-1:0] p,
                        input bit use_t, input exp_t te);
        exp_t e;
        int   c;
        int   r;
        @(negedge clock);
        bus.pix_valid = v;
        bus.sof       = s;
        bus.pix_in    = p;
        if (v && (s || m_active)) begin
            c     = s ? 0 : m_col;
            r     = s ? 0 : m_row;
            e.lb0 = p;
            e.lb1 = (r == 0) ? '0 : m_ram[c];
            e.col = c;
            e.row = r;
            e.fd  = (c == W-1) && (r == H-1);
            m_ram[c] = p;
            if (e.fd) begin
                m_active = 0; m_col = 0; m_row = 0;
            end else begin
                m_active = 1;
                if (c == W-1) begin m_col = 0; m_row = r + 1; end
                else          m_col = c + 1;
            end
            q.push_back(use_t ? te : e);
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [PW-1:0] p);
        exp_t z;
        z = '{default: 0};
        step(v, s, p, 1'b0, z);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic frame(input int base, input bit bubbles);
        for (int i = 0; i < W*H; i++) begin
            drive(1'b1, i == 0, PW'(base + i));
            if (bubbles) idle(1);
        end
    endtask

    task automatic settle(input string name, input int fd_exp);
        idle(2);
        chk({name, " pending outputs"}, q.size(), 0);
        chk({name, " frame_done count"}, fd_seen, fd_exp);
        fd_seen = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, " clken"}, bus.clken, 0);
        chk({name, " lb0"}, bus.linebuffer0, 0);
        chk({name, " lb1"}, bus.linebuffer1, 0);
        chk({name, " col_cnt"}, bus.col_cnt, 0);
        chk({name, " row_cnt"}, bus.row_cnt, 0);
        chk({name, " frame_done"}, bus.frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = '0;
        m_active = 0; m_col = 0; m_row = 0;

        // Reference frame 1..12 with explicitly tabulated outputs
        for (int i = 0; i < W*H; i++) begin
            tbl[i].sof     = (i == 0);
            tbl[i].pix     = PW'(i + 1);
            tbl[i].exp.lb0 = PW'(i + 1);
            tbl[i].exp.lb1 = (i < W) ? '0 : PW'(i + 1 - W);
            tbl[i].exp.col = i % W;
            tbl[i].exp.row = i / W;
            tbl[i].exp.fd  = (i == W*H - 1);
        end

        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        #3 rst = 1'b1;

        // pix_valid without sof after reset must be dropped
        drive(1'b1, 1'b0, 11'd7);
        drive(1'b1, 1'b0, 11'd7);
        settle("discard", 0);
        chk_zero("discard");

        for (int i = 0; i < W*H; i++)
            step(1'b1, tbl[i].sof, tbl[i].pix, 1'b1, tbl[i].exp);
        settle("table frame", 1);

        frame(1, 1'b1);
        settle("bubbles", 1);

        // Abort after six pixels, restart with 100..111
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, PW'(i + 1));
        frame(100, 1'b0);
        settle("restart", 1);

        // Asynchronous reset mid-frame, checked before the next clock edge
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, PW'(i + 1));
        idle(1);
        #2 rst = 1'b0;
        #1 chk_zero("async reset");
        m_active = 0; m_col = 0; m_row = 0;
        @(negedge clock);
        #3 rst = 1'b1;
        frame(20, 1'b0);
        settle("after reset", 1);

        frame(1, 1'b0);
        frame(21, 1'b0);
        settle("back to back", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
